// File: rtl/game_pkg.sv
// Shared constants and types for the game's pseudo-random word generator.
package game_pkg;

  localparam int unsigned LFSR_W  = 9;
  localparam int unsigned TAP_HI  = 8;
  localparam int unsigned TAP_LO  = 4;
  localparam int unsigned LOCK_W  = 4;
  localparam logic [LFSR_W-1:0] Q1_MASK = 9'h1A5;

  typedef logic [LFSR_W-1:0] word_t;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } rs_state_e;

endpackage

// File: rtl/lfsr9_step.sv
// One combinational LFSR step (x^9+x^5+1) with entropy mixing and zero-lockup guard.
module lfsr9_step
  import game_pkg::*;
(
  input  logic [LFSR_W-1:0] src,
  input  logic              adv,
  input  logic              ent,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] nxt_c,
  output logic              hit_c
);

  word_t raw;

  always_comb begin
    raw   = src;
    if (adv) begin
      raw = {src[LFSR_W-2:0], src[TAP_HI] ^ src[TAP_LO] ^ ent};
    end
    nxt_c = raw;
    hit_c = 1'b0;
    // An all-zero lane would lock up forever; restart it from its seed.
    if (raw == '0) begin
      nxt_c = seed;
      hit_c = 1'b1;
    end
  end

endmodule

// File: rtl/random_source.sv
// Three free-running 9-bit LFSR lanes with seeding, warm-up, button entropy
// on the sign lane and zero-state recovery counting.
module random_source
  import game_pkg::*;
#(
  parameter int unsigned       WARMUP  = 16,
  parameter logic [LFSR_W-1:0] SEED0   = 9'h001,
  parameter logic [LFSR_W-1:0] SEED1   = 9'h0FF,
  parameter logic [LFSR_W-1:0] SEEDNEG = 9'h155
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              step_en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              entropy_in,
  output logic [LFSR_W-1:0] Q0,
  output logic [LFSR_W-1:0] Q1,
  output logic [LFSR_W-1:0] Qneg,
  output logic              ready,
  output logic [LOCK_W-1:0] lockup_cnt
);

  localparam int unsigned CNT_W   = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned WU_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
  localparam int unsigned SUM_W   = LOCK_W + 1;
  localparam rs_state_e   INIT_ST = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  rs_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             adv;
  logic             ent_meta, ent_s;

  word_t src0, src1, srcn;
  word_t nxt0, mid1, nxt1, nxtn;
  logic  hit0, hit1a, hit1b, hitn;
  logic [SUM_W-1:0]  lk_sum;
  logic [LOCK_W-1:0] lk_nxt;

  // Sequencing: seed_load beats warm-up forced stepping, which beats step_en.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    if (seed_load) begin
      state_nxt = INIT_ST;
      cnt_nxt   = '0;
    end else if (state == ST_WARMUP) begin
      adv = 1'b1;
      if (cnt == CNT_W'(WU_LAST)) begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      adv = step_en;
    end
  end

  assign src0 = seed_load ? seed_in : Q0;
  assign src1 = seed_load ? ({seed_in[3:0], seed_in[8:4]} ^ Q1_MASK) : Q1;
  assign srcn = seed_load ? ~seed_in : Qneg;

  lfsr9_step u_q0 (
    .src(src0), .adv(adv), .ent(1'b0), .seed(SEED0), .nxt_c(nxt0), .hit_c(hit0)
  );

  // Q1 advances two steps per cycle through a chained pair.
  lfsr9_step u_q1a (
    .src(src1), .adv(adv), .ent(1'b0), .seed(SEED1), .nxt_c(mid1), .hit_c(hit1a)
  );

  lfsr9_step u_q1b (
    .src(mid1), .adv(adv), .ent(1'b0), .seed(SEED1), .nxt_c(nxt1), .hit_c(hit1b)
  );

  lfsr9_step u_qn (
    .src(srcn), .adv(adv), .ent(ent_s), .seed(SEEDNEG), .nxt_c(nxtn), .hit_c(hitn)
  );

  assign lk_sum = {1'b0, lockup_cnt} + SUM_W'(hit0) + SUM_W'(hit1a | hit1b) + SUM_W'(hitn);
  assign lk_nxt = lk_sum[LOCK_W] ? '1 : lk_sum[LOCK_W-1:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= INIT_ST;
      cnt        <= '0;
      ready      <= (WARMUP == 0);
      Q0         <= SEED0;
      Q1         <= SEED1;
      Qneg       <= SEEDNEG;
      lockup_cnt <= '0;
      ent_meta   <= 1'b0;
      ent_s      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ready      <= (state_nxt == ST_RUN);
      Q0         <= nxt0;
      Q1         <= nxt1;
      Qneg       <= nxtn;
      lockup_cnt <= lk_nxt;
      ent_meta   <= entropy_in;
      ent_s      <= ent_meta;
    end
  end

endmodule

// File: tb/tb_random_source.sv
// Bench for random_source: WARMUP=4 and WARMUP=0 instances against a reference model and hand vectors.
module tb_random_source;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       step_en = 1'b0;
  logic       seed_load = 1'b0;
  logic [8:0] seed_in = '0;
  logic       entropy_in = 1'b0;

  logic [8:0] a_q0, a_q1, a_qn, b_q0, b_q1, b_qn;
  logic       a_rdy, b_rdy;
  logic [3:0] a_lk, b_lk;

  always #5 Clock = ~Clock;

  random_source #(.WARMUP(4)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .step_en(step_en), .seed_load(seed_load),
    .seed_in(seed_in), .entropy_in(entropy_in), .Q0(a_q0), .Q1(a_q1), .Qneg(a_qn),
    .ready(a_rdy), .lockup_cnt(a_lk)
  );

  random_source #(.WARMUP(0)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .step_en(step_en), .seed_load(seed_load),
    .seed_in(seed_in), .entropy_in(entropy_in), .Q0(b_q0), .Q1(b_q1), .Qneg(b_qn),
    .ready(b_rdy), .lockup_cnt(b_lk)
  );

  typedef struct {
    logic [8:0] q0, q1, qn;
    logic       ready;
    logic [3:0] lk;
  } out_t;

  typedef struct {
    logic [8:0] q0, q1, qn;
    logic       ready;
    logic [3:0] lk;
    logic       s1, s2, run;
    int         cnt;
  } mdl_t;

  typedef struct {
    logic       se, sl;
    logic [8:0] si;
    logic [8:0] q0, q1, qn;
    logic [3:0] lk;
  } vec_t;

  mdl_t ma, mb;
  out_t sb_a[$];
  out_t sb_b[$];
  vec_t tbl[7];
  int   total = 0;
  int   bad = 0;

  function automatic logic [8:0] lf(logic [8:0] x, logic e);
    return {x[7:0], x[8] ^ x[4] ^ e};
  endfunction

  function automatic mdl_t mreset(int wu);
    mdl_t m;
    m.q0 = 9'h001; m.q1 = 9'h0FF; m.qn = 9'h155;
    m.ready = (wu == 0); m.lk = 4'd0;
    m.s1 = 1'b0; m.s2 = 1'b0; m.run = (wu == 0); m.cnt = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int wu, logic se, logic sl, logic [8:0] si, logic ent);
    mdl_t n;
    int hits;
    n = m;
    hits = 0;
    n.s1 = ent;
    n.s2 = m.s1;
    if (sl) begin
      n.q0 = si;
      n.q1 = {si[3:0], si[8:4]} ^ 9'h1A5;
      n.qn = ~si;
      n.cnt = 0;
      n.run = (wu == 0);
    end else if (!m.run || se) begin
      n.q0 = lf(m.q0, 1'b0);
      n.q1 = lf(lf(m.q1, 1'b0), 1'b0);
      n.qn = lf(m.qn, m.s2);
      if (!m.run) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == wu) begin
          n.run = 1'b1;
          n.cnt = 0;
        end
      end
    end
    if (n.q0 == 9'h000) begin n.q0 = 9'h001; hits++; end
    if (n.q1 == 9'h000) begin n.q1 = 9'h0FF; hits++; end
    if (n.qn == 9'h000) begin n.qn = 9'h155; hits++; end
    n.lk = (int'(m.lk) + hits > 15) ? 4'd15 : 4'(int'(m.lk) + hits);
    n.ready = n.run;
    return n;
  endfunction

  function automatic out_t to_out(mdl_t m);
    out_t o;
    o.q0 = m.q0; o.q1 = m.q1; o.qn = m.qn; o.ready = m.ready; o.lk = m.lk;
    return o;
  endfunction

  function automatic out_t get_a();
    out_t o;
    o.q0 = a_q0; o.q1 = a_q1; o.qn = a_qn; o.ready = a_rdy; o.lk = a_lk;
    return o;
  endfunction

  function automatic out_t get_b();
    out_t o;
    o.q0 = b_q0; o.q1 = b_q1; o.qn = b_qn; o.ready = b_rdy; o.lk = b_lk;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(string tag, out_t act, out_t exp);
    chk({tag, ".q0"}, 32'(act.q0), 32'(exp.q0));
    chk({tag, ".q1"}, 32'(act.q1), 32'(exp.q1));
    chk({tag, ".qneg"}, 32'(act.qn), 32'(exp.qn));
    chk({tag, ".ready"}, 32'(act.ready), 32'(exp.ready));
    chk({tag, ".lockup"}, 32'(act.lk), 32'(exp.lk));
  endtask

  // Drive one cycle, queue predictions, then compare once the edge has passed.
  task automatic cycle(logic se, logic sl, logic [8:0] si, logic ent);
    out_t ea, eb;
    step_en = se; seed_load = sl; seed_in = si; entropy_in = ent;
    ma = mstep(ma, 4, se, sl, si, ent);
    mb = mstep(mb, 0, se, sl, si, ent);
    sb_a.push_back(to_out(ma));
    sb_b.push_back(to_out(mb));
    @(posedge Clock);
    #1;
    ea = sb_a.pop_front();
    eb = sb_b.pop_front();
    cmp_out("sb_a", get_a(), ea);
    cmp_out("sb_b", get_b(), eb);
  endtask

  // Asynchronous reset pulse between edges; values must appear with no clock edge.
  task automatic do_reset();
    @(posedge Clock);
    #1;
    step_en = 1'b0; seed_load = 1'b0; seed_in = '0; entropy_in = 1'b0;
    Resetn = 1'b0;
    #2;
    chk("rst_a_q0", 32'(a_q0), 32'h001);
    chk("rst_a_q1", 32'(a_q1), 32'h0FF);
    chk("rst_a_qneg", 32'(a_qn), 32'h155);
    chk("rst_a_ready", 32'(a_rdy), 32'h0);
    chk("rst_a_lockup", 32'(a_lk), 32'h0);
    chk("rst_b_q0", 32'(b_q0), 32'h001);
    chk("rst_b_ready", 32'(b_rdy), 32'h1);
    chk("rst_b_lockup", 32'(b_lk), 32'h0);
    Resetn = 1'b1;
    ma = mreset(4);
    mb = mreset(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0]   exp_w [4];
    logic [8:0]   start, v;
    logic [511:0] seen;

    tbl[0] = '{1'b1, 1'b0, 9'h000, 9'h002, 9'h1FE, 9'h0AA, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 9'h000, 9'h002, 9'h1FE, 9'h0AA, 4'd0};
    tbl[2] = '{1'b0, 1'b1, 9'h000, 9'h001, 9'h1A5, 9'h1FF, 4'd1};
    tbl[3] = '{1'b1, 1'b1, 9'h000, 9'h001, 9'h1A5, 9'h1FF, 4'd2};
    tbl[4] = '{1'b1, 1'b0, 9'h000, 9'h002, 9'h097, 9'h1FE, 4'd2};
    tbl[5] = '{1'b0, 1'b1, 9'h123, 9'h123, 9'h1D7, 9'h0DC, 4'd2};
    tbl[6] = '{1'b0, 1'b1, 9'h05D, 9'h05D, 9'h0FF, 9'h1A2, 4'd3};

    exp_w[0] = 9'h002; exp_w[1] = 9'h004; exp_w[2] = 9'h008; exp_w[3] = 9'h010;

    // Reset, partial warm-up, then reset again mid-warm-up.
    do_reset();
    cycle(1'b0, 1'b0, 9'h000, 1'b0);
    cycle(1'b0, 1'b0, 9'h000, 1'b0);
    do_reset();

    // Warm-up walk of Q0 with step_en low, then hold and a single step.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 9'h000, 1'b0);
      chk("warm_q0", 32'(a_q0), 32'(exp_w[i]));
      chk("warm_ready", 32'(a_rdy), (i == 3) ? 32'h1 : 32'h0);
    end
    cycle(1'b0, 1'b0, 9'h000, 1'b0);
    cycle(1'b0, 1'b0, 9'h000, 1'b0);
    chk("hold_q0", 32'(a_q0), 32'h010);
    cycle(1'b1, 1'b0, 9'h000, 1'b0);
    chk("step_q0", 32'(a_q0), 32'h021);
    cycle(1'b0, 1'b0, 9'h000, 1'b0);
    chk("hold2_q0", 32'(a_q0), 32'h021);

    // Hand vectors on the WARMUP=0 instance.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].se, tbl[i].sl, tbl[i].si, 1'b0);
      chk($sformatf("tbl%0d_q0", i), 32'(b_q0), 32'(tbl[i].q0));
      chk($sformatf("tbl%0d_q1", i), 32'(b_q1), 32'(tbl[i].q1));
      chk($sformatf("tbl%0d_qneg", i), 32'(b_qn), 32'(tbl[i].qn));
      chk($sformatf("tbl%0d_lockup", i), 32'(b_lk), 32'(tbl[i].lk));
      chk($sformatf("tbl%0d_ready", i), 32'(b_rdy), 32'h1);
    end

    // Entropy drives Qneg to zero; guard restores SEEDNEG.
    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 9'h000, 1'b1);
    cycle(1'b0, 1'b1, 9'h0FF, 1'b1);
    chk("ent_load_qneg", 32'(b_qn), 32'h100);
    cycle(1'b1, 1'b0, 9'h000, 1'b1);
    chk("ent_qneg", 32'(b_qn), 32'h155);
    chk("ent_lockup", 32'(b_lk), 32'h1);
    chk("ent_q0", 32'(b_q0), 32'h1FF);

    // seed_load and step_en together in RUN: load wins, ready drops.
    do_reset();
    repeat (4) cycle(1'b0, 1'b0, 9'h000, 1'b0);
    chk("coll_pre_ready", 32'(a_rdy), 32'h1);
    cycle(1'b1, 1'b1, 9'h123, 1'b0);
    chk("coll_q0", 32'(a_q0), 32'h123);
    chk("coll_ready", 32'(a_rdy), 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 9'h000, 1'b0);
    chk("coll_ready_back", 32'(a_rdy), 32'h1);

    // Full period of Q0.
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 9'h000, 1'b0);
    start = a_q0;
    seen = '0;
    seen[start] = 1'b1;
    for (int k = 1; k <= 511; k++) begin
      cycle(1'b1, 1'b0, 9'h000, 1'b0);
      v = a_q0;
      if (k < 511) begin
        chk("period_nonzero", 32'(v != 9'h000), 32'h1);
        chk("period_distinct", 32'(seen[v]), 32'h0);
        seen[v] = 1'b1;
      end else begin
        chk("period_return", 32'(v), 32'(start));
      end
    end

    // Random traffic on both instances against the model.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(1)), ($urandom_range(15) == 0),
            ($urandom_range(3) == 0) ? 9'h000 : 9'($urandom), 1'($urandom_range(1)));
    end

    // lockup_cnt saturation.
    do_reset();
    repeat (16) cycle(1'b0, 1'b1, 9'h000, 1'b0);
    chk("sat_b_lockup", 32'(b_lk), 32'hF);
    chk("sat_a_lockup", 32'(a_lk), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
